// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared codes, segment patterns and FSM states for the segment scan decoder
package seg_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] CODE_DASH    = 5'd16;
  localparam logic [CODE_W-1:0] CODE_INVALID = 5'd30;
  localparam logic [CODE_W-1:0] CODE_BLANK   = 5'd31;

  // Active-low g..a patterns
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_6_ALT = 7'b0000011;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_9_ALT = 7'b0011000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational 7-segment pattern to code decoder
// Define SEG_HEX_EN to also recognise A-F (0000011 then reads as b instead of 6).
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0]        pattern,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = CODE_INVALID;
    case (pattern)
      SEG_0:     code = 5'd0;
      SEG_1:     code = 5'd1;
      SEG_2:     code = 5'd2;
      SEG_3:     code = 5'd3;
      SEG_4:     code = 5'd4;
      SEG_5:     code = 5'd5;
      SEG_6:     code = 5'd6;
`ifdef SEG_HEX_EN
      SEG_6_ALT: code = 5'd11;
      SEG_A:     code = 5'd10;
      SEG_C:     code = 5'd12;
      SEG_D:     code = 5'd13;
      SEG_E:     code = 5'd14;
      SEG_F:     code = 5'd15;
`else
      SEG_6_ALT: code = 5'd6;
`endif
      SEG_7:     code = 5'd7;
      SEG_8:     code = 5'd8;
      SEG_9:     code = 5'd9;
      SEG_9_ALT: code = 5'd9;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - samples a multiplexed active-low 7-segment bus, debounces each digit
// and presents one decoded frame per full scan on a valid/ready output.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SAMPLE_DIV = 16,
  parameter int STABLE_CNT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   seg_in,
  input  logic [NUM_DIGITS-1:0]        an_in,
  output logic [CODE_W*NUM_DIGITS-1:0] out_code,
  output logic [NUM_DIGITS-1:0]        out_dp,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  logic [DIV_W-1:0]             div_cnt;
  logic                         tick;
  logic [NUM_DIGITS-1:0]        an_low;
  logic                         one_low;
  logic [IDX_W-1:0]             idx;
  logic                         last_valid;
  logic [IDX_W-1:0]             last_idx;
  logic [7:0]                   last_seg;
  logic [CNT_W-1:0]             cnt;
  logic                         match;
  logic                         capture;
  logic [CODE_W-1:0]            seg_code;
  logic [CODE_W*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]        shadow_dp;
  logic [NUM_DIGITS-1:0]        captured;
  logic                         frame_done;
  state_t                       state, state_next;
  logic                         load, drop;

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  assign an_low  = ~an_in;
  assign one_low = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (an_low[k]) idx = IDX_W'(k);
  end

  seg_pattern_decode u_decode (
    .pattern (seg_in[6:0]),
    .code    (seg_code)
  );

  // A pattern is accepted only on the tick where the run length first reaches STABLE_CNT
  assign match   = last_valid && (idx == last_idx) && (seg_in == last_seg);
  assign capture = tick && one_low &&
                   (match ? (cnt == CNT_W'(STABLE_CNT - 1)) : (STABLE_CNT == 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_idx   <= '0;
      last_seg   <= '1;
      cnt        <= '0;
    end else if (tick) begin
      if (one_low) begin
        last_valid <= 1'b1;
        last_idx   <= idx;
        last_seg   <= seg_in;
        if (!match)                         cnt <= CNT_W'(1);
        else if (cnt < CNT_W'(STABLE_CNT))  cnt <= cnt + CNT_W'(1);
      end else begin
        last_valid <= 1'b0;
        cnt        <= '0;
      end
    end
  end

  assign frame_done = &captured;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '1;
      shadow_dp <= '0;
      captured  <= '0;
    end else begin
      if (capture) begin
        shadow[idx*CODE_W +: CODE_W] <= seg_code;
        shadow_dp[idx]               <= ~seg_in[7];
      end
      // A completed frame is always consumed (loaded or dropped), so clear before merging new captures
      captured <= (frame_done ? '0 : captured) | (capture ? an_low : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (frame_done) begin
          load       = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (frame_done) begin
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_next = ST_COLLECT;
        end
      end
      default: state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_code <= '1;
      out_dp   <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        out_code <= shadow;
        out_dp   <= shadow_dp;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder with a table-driven frame model
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SD = 1;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    seg_in;
  logic [ND-1:0] an_in;
  logic [5*ND-1:0] out_code;
  logic [ND-1:0] out_dp;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(ND), .SAMPLE_DIV(SD), .STABLE_CNT(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .out_code  (out_code),
    .out_dp    (out_dp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [5*ND-1:0] code;
    logic [ND-1:0]   dp;
  } frame_t;

  localparam int NBASE = 14;
  localparam logic [6:0] BASE_PAT [NBASE] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
    7'b0000011, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0011000, 7'b0111111, 7'b1111111};
  localparam logic [4:0] BASE_CODE [NBASE] = '{
    5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd6, 5'd7, 5'd8, 5'd9, 5'd9, 5'd16, 5'd31};
  localparam int NHEX = 6;
  localparam logic [6:0] HEX_PAT [NHEX] = '{
    7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [4:0] HEX_CODE [NHEX] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  frame_t        exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [4:0]    m_code [ND];
  logic          m_dp [ND];
  logic [ND-1:0] m_cap;
  bit            drop_next;
  bit            ready_mode;
  logic          ready_force;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'd30;
    for (int i = 0; i < NBASE; i++)
      if (p == BASE_PAT[i]) r = BASE_CODE[i];
`ifdef SEG_HEX_EN
    for (int i = 0; i < NHEX; i++)
      if (p == HEX_PAT[i]) r = HEX_CODE[i];
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pick_seg(output logic [7:0] s);
    case ($urandom_range(0, 2))
      0:       s[6:0] = BASE_PAT[$urandom_range(0, NBASE - 1)];
      1:       s[6:0] = HEX_PAT[$urandom_range(0, NHEX - 1)];
      default: s[6:0] = 7'($urandom);
    endcase
    s[7] = 1'($urandom_range(0, 1));
  endtask

  task automatic model_capture(input int idx, input logic [7:0] s);
    frame_t f;
    m_code[idx] = ref_decode(s[6:0]);
    m_dp[idx]   = ~s[7];
    m_cap[idx]  = 1'b1;
    if (&m_cap) begin
      for (int i = 0; i < ND; i++) begin
        f.code[5*i +: 5] = m_code[i];
        f.dp[i]          = m_dp[i];
      end
      if (!drop_next) exp_q.push_back(f);
      m_cap = '0;
    end
  endtask

  task automatic show(input int idx, input logic [7:0] s, input int n);
    an_in      = '1;
    an_in[idx] = 1'b0;
    seg_in     = s;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic blank(input int n);
    an_in  = '1;
    seg_in = 8'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic digit_fixed(input int idx, input logic [7:0] s);
    show(idx, s, SC);
    model_capture(idx, s);
    show(idx, s, 2);
    blank(2);
  endtask

  task automatic digit_rand(input int idx, input logic [7:0] s, input bit glitch);
    if (glitch) show(idx, s ^ 8'($urandom_range(1, 255)), $urandom_range(1, SC - 1));
    show(idx, s, SC);
    model_capture(idx, s);
    show(idx, s, $urandom_range(0, 3));
    blank($urandom_range(1, 3));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", {31'd0, (exp_q.size() != 0 || out_valid)}, 32'd0);
  endtask

  // Monitor: every negedge with valid && ready is a handshake at the next posedge
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got code %0h dp %0h expected none", out_code, out_dp);
        end else begin
          f = exp_q.pop_front();
          check("frame_code", 32'(out_code), 32'(f.code));
          check("frame_dp", 32'(out_dp), 32'(f.dp));
        end
      end
    end
  end

  initial begin
    int lowrun;
    lowrun    = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ready_mode) begin
        out_ready = ready_force;
      end else if (out_valid && lowrun >= 2) begin
        out_ready = 1'b1;
        lowrun    = 0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        lowrun    = out_ready ? 0 : lowrun + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    frame_t     fa;
    rst = 1'b1; an_in = '1; seg_in = '1;
    ready_mode = 1'b0; ready_force = 1'b0; drop_next = 1'b0; m_cap = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_code", 32'(out_code), 32'hFFFFF);
    check("reset_dp", 32'(out_dp), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;

    // digits 1,2,3,4 on positions 0..3
    for (int i = 0; i < ND; i++) digit_fixed(i, {1'b1, BASE_PAT[i + 1]});
    wait_drain();

    // glitch: 0 for three samples, then 1
    show(0, 8'hC0, SC - 1);
    show(0, 8'hF9, SC);
    model_capture(0, 8'hF9);
    blank(2);
    for (int i = 1; i < ND; i++) begin pick_seg(s); digit_fixed(i, s); end
    wait_drain();

    digit_fixed(0, 8'h3F);
    digit_fixed(1, 8'h7F);
    digit_fixed(2, 8'h55);
    digit_fixed(3, 8'h83);
    wait_drain();

    repeat (25) begin
      do begin
        pick_seg(s);
        digit_rand($urandom_range(0, ND - 1), s, 1'($urandom_range(0, 1)));
      end while (m_cap != '0);
    end
    wait_drain();
    check("no_overflow_random", 32'(overflow), 32'd0);

    // two digit enables low must reset the run length
    for (int i = 0; i < 3; i++) begin pick_seg(s); digit_fixed(i, s); end
    pick_seg(s);
    show(3, s, SC - 1);
    an_in = 4'b0011;
    repeat (10) begin @(posedge clk); #1; end
    show(3, s, SC - 1);
    blank(2);
    @(negedge clk);
    check("dual_low_no_capture", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    pick_seg(s);
    digit_fixed(3, s);
    wait_drain();

    // overflow: second frame completes while consumer stalls
    ready_mode = 1'b1; ready_force = 1'b0;
    for (int i = 0; i < ND; i++) begin pick_seg(s); digit_fixed(i, s); end
    fa = exp_q[exp_q.size() - 1];
    @(negedge clk);
    check("hold_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    drop_next = 1'b1;
    for (int i = 0; i < ND; i++) begin pick_seg(s); digit_fixed(i, s); end
    drop_next = 1'b0;
    @(negedge clk);
    check("overflow_set", 32'(overflow), 32'd1);
    check("overflow_code_kept", 32'(out_code), 32'(fa.code));
    check("overflow_dp_kept", 32'(out_dp), 32'(fa.dp));
    @(posedge clk); #1;
    ready_force = 1'b1;
    @(negedge clk);
    check("valid_before_accept", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("valid_after_accept", 32'(out_valid), 32'd0);
    check("queue_after_accept", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    ready_mode = 1'b0;

    // reset mid-collection discards partial frame
    pick_seg(s); digit_fixed(0, s);
    pick_seg(s); digit_fixed(1, s);
    rst   = 1'b1;
    m_cap = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_code", 32'(out_code), 32'hFFFFF);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    pick_seg(s); digit_fixed(2, s);
    pick_seg(s); digit_fixed(3, s);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_partial_no_frame", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    pick_seg(s); digit_fixed(0, s);
    pick_seg(s); digit_fixed(1, s);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
